fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 2: number of decode-stage source operands checked.
REQ-002 SHALL have parameter NSTAGE, default 3: number of tracked writer stages (1=EX, 2=MEM, 3=WB).
REQ-003 SHALL have parameter RAW, default 5: register address width.
REQ-004 SHALL have parameter MC_LAT, default 4: cycles a multicycle op occupies stage 1 (MC_LAT >= 1).
REQ-005 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 id_valid  in  1  decode instruction present.
REQ-008 id_rs  in  NSRC x RAW  decode source registers.
REQ-009 id_rs_used  in  NSRC  source i actually read.
REQ-010 id_rd  in  RAW  decode destination register.
REQ-011 id_reg_write  in  1  decode instruction writes regfile.
REQ-012 id_is_load  in  1  decode instruction is a load.
REQ-013 id_is_mc  in  1  decode instruction is multicycle (mul/div).
REQ-014 flush  in  1  kill decode instruction (taken branch/redirect).
REQ-015 fwd_sel  out  NSRC x $clog2(NSTAGE+1)  0 = regfile, k = forward from stage k.
REQ-016 stall  out  1  hold IF/ID, insert bubble.
REQ-017 mc_busy  out  1  multicycle op occupying stage 1.

Function
REQ-018 SHALL keep a tag per stage k: {valid, rd, reg_write, is_load, is_mc}.
REQ-019 Advance (no stall, no mc_busy): stage1 <= decode tag if id_valid && !flush, else empty; stage k <= stage k-1; stage NSTAGE tag retires.
REQ-020 Stall without mc_busy: stage1 <= empty (bubble); stages 2..NSTAGE shift normally.
REQ-021 Stage k matches source i iff valid && reg_write && rd != 0 && rd == id_rs[i] && id_rs_used[i].
REQ-022 fwd_sel[i] SHALL be the lowest matching k (youngest writer wins), else 0; combinational from registered tags, zero latency.
REQ-023 Load-use: stage1 match with is_load SHALL assert stall; fwd_sel[i] then points to the next older match or 0 (don't-care for the held instruction).
REQ-024 When an is_mc tag enters stage1, counter SHALL load MC_LAT-1; mc_busy = (counter != 0).
REQ-025 While mc_busy: stage1 frozen, stage2 receives empty, stages 3..NSTAGE shift, counter decrements, stall = id_valid.
REQ-026 stall = id_valid && !flush && (load-use on any used source || mc_busy).
REQ-027 flush SHALL override stall: stall = 0, decode tag not captured; in-flight tags and counter unaffected.
REQ-028 MC_LAT = 1: mc op behaves as single-cycle, mc_busy never asserts.
REQ-029 rd = 0 SHALL never match; unused sources SHALL output fwd_sel 0.

Reset
REQ-030 rst SHALL asynchronously clear all stage valid bits and counter to 0.
REQ-031 During/after reset: fwd_sel all 0, mc_busy 0, stall 0 while all stages empty.
REQ-032 rst mid-multicycle SHALL abort the op immediately; first post-reset edge captures decode normally.

Structure
REQ-033 Tag struct and fwd_sel width helper SHALL live in control_pkg, next to fwd_sel_e.
REQ-034 Tag shift register with freeze/bubble control SHALL be sub-module fwd_tag_pipe (params NSTAGE, RAW).
REQ-035 Match/priority logic SHALL be a generate loop over NSRC.

Verification
REQ-036 add x5 issued, next cycle rs1=x5 used -> fwd_sel[0]=1, stall=0; following cycle (new instr rs1=x5) -> fwd_sel[0]=2.
REQ-037 lw x7, next instr rs2=x7 -> stall=1 one cycle, then fwd_sel[1]=2, stall=0.
REQ-038 x3 written in stages 1 and 3, rs1=x3 -> fwd_sel[0]=1; rd=x0 writer with rs1=x0 -> fwd_sel[0]=0.
REQ-039 div x9 (MC_LAT=4), id_valid held -> mc_busy and stall high exactly 3 cycles, then rs1=x9 -> fwd_sel[0]=1.
REQ-040 Load-use hazard with flush=1 same cycle -> stall=0, stage1 empty next cycle; rst asserted during mc_busy -> mc_busy=0, all fwd_sel=0 immediately.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types for the forwarding/hazard controller: per-stage writer tags
// and the forward-select encoding.
package control_pkg;

    localparam int MAX_RAW = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [MAX_RAW-1:0] rd;
        logic               reg_write;
        logic               is_load;
        logic               is_mc;
    } tag_t;

    function automatic int fwd_sel_width(input int nstage);
        return (nstage < 1) ? 1 : $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Writer-tag shift register. Freeze holds stage 1 (multicycle op resident)
// and feeds stage 2 a bubble; otherwise stage 1 takes the decode tag or a bubble.
module fwd_tag_pipe
    import control_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RAW    = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_freeze,
    input  logic i_capture,
    input  tag_t i_tag,
    output tag_t o_tag [1:NSTAGE]
);

    localparam logic [MAX_RAW-1:0] RD_MASK = MAX_RAW'((1 << RAW) - 1);

    logic r_vld [1:NSTAGE];
    tag_t r_tag [1:NSTAGE];
    tag_t w_in;

    always_comb begin
        w_in    = i_tag;
        w_in.rd = i_tag.rd & RD_MASK;
    end

    // Only the valid bits carry reset; payload is qualified by them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 1; k <= NSTAGE; k++) r_vld[k] <= 1'b0;
        end else begin
            if (!i_freeze) r_vld[1] <= i_capture;
            for (int k = 2; k <= NSTAGE; k++)
                r_vld[k] <= (i_freeze && k == 2) ? 1'b0 : r_vld[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_freeze) r_tag[1] <= w_in;
        for (int k = 2; k <= NSTAGE; k++) r_tag[k] <= r_tag[k-1];
    end

    always_comb begin
        for (int k = 1; k <= NSTAGE; k++) begin
            o_tag[k]       = r_tag[k];
            o_tag[k].valid = r_vld[k];
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select, load-use stall and multicycle-occupancy control
// for the decode stage, driven from registered writer tags of later stages.
module fwd_hazard_ctrl
    import control_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int NSTAGE = 3,
    parameter int RAW    = 5,
    parameter int MC_LAT = 4
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_id_valid,
    input  logic [NSRC-1:0][RAW-1:0]                   i_id_rs,
    input  logic [NSRC-1:0]                            i_id_rs_used,
    input  logic [RAW-1:0]                             i_id_rd,
    input  logic                                       i_id_reg_write,
    input  logic                                       i_id_is_load,
    input  logic                                       i_id_is_mc,
    input  logic                                       i_flush,
    output logic [NSRC-1:0][fwd_sel_width(NSTAGE)-1:0] o_fwd_sel,
    output logic                                       o_stall,
    output logic                                       o_mc_busy
);

    localparam int SELW  = fwd_sel_width(NSTAGE);
    localparam int CNT_W = $clog2(MC_LAT + 1);

    tag_t             w_tag [1:NSTAGE];
    tag_t             w_id_tag;
    logic [NSRC-1:0]  w_lu;
    logic             w_busy;
    logic             w_stall;
    logic             w_capture;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_id_tag           = '0;
        w_id_tag.valid     = 1'b1;
        w_id_tag.rd        = MAX_RAW'(i_id_rd);
        w_id_tag.reg_write = i_id_reg_write;
        w_id_tag.is_load   = i_id_is_load;
        w_id_tag.is_mc     = i_id_is_mc;
    end

    // Scanning oldest to youngest lets the youngest writer overwrite; a load
    // in stage 1 has no data yet, so it flags load-use and leaves older matches.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [SELW-1:0] w_sel;
        logic            w_hit_load;

        always_comb begin
            w_sel      = SELW'(FWD_RF);
            w_hit_load = 1'b0;
            for (int k = NSTAGE; k >= 1; k--) begin
                if (w_tag[k].valid && w_tag[k].reg_write && (w_tag[k].rd != '0) &&
                    (w_tag[k].rd == MAX_RAW'(i_id_rs[i])) && i_id_rs_used[i]) begin
                    if (k == 1 && w_tag[k].is_load) w_hit_load = 1'b1;
                    else                            w_sel      = SELW'(k);
                end
            end
        end

        assign o_fwd_sel[i] = w_sel;
        assign w_lu[i]      = w_hit_load;
    end

    assign w_busy    = (r_cnt != '0);
    assign w_stall   = i_id_valid && !i_flush && ((|w_lu) || w_busy);
    assign w_capture = i_id_valid && !i_flush && !w_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                          r_cnt <= '0;
        else if (w_busy)                    r_cnt <= r_cnt - CNT_W'(1);
        else if (w_capture && i_id_is_mc)   r_cnt <= CNT_W'(MC_LAT - 1);
    end

    fwd_tag_pipe #(
        .NSTAGE (NSTAGE),
        .RAW    (RAW)
    ) u_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_freeze  (w_busy),
        .i_capture (w_capture),
        .i_tag     (w_id_tag),
        .o_tag     (w_tag)
    );

    assign o_stall   = w_stall;
    assign o_mc_busy = w_busy;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: two controllers (MC_LAT=4 and MC_LAT=1) share stimulus;
// a stage-list reference model queues expected outputs, a monitor compares.
module tb_fwd_hazard_ctrl;

    localparam int NSRC   = 2;
    localparam int NSTAGE = 3;
    localparam int RAW    = 5;
    localparam int MC_LAT = 4;
    localparam int SELW   = 2;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [NSRC-1:0][RAW-1:0] id_rs;
    logic [NSRC-1:0] id_rs_used;
    logic [RAW-1:0] id_rd;
    logic id_reg_write, id_is_load, id_is_mc, flush;
    logic [NSRC-1:0][SELW-1:0] fwd_sel0, fwd_sel1;
    logic stall0, stall1, busy0, busy1;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.NSRC(NSRC), .NSTAGE(NSTAGE), .RAW(RAW), .MC_LAT(MC_LAT)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rs_used(id_rs_used), .i_id_rd(id_rd), .i_id_reg_write(id_reg_write),
        .i_id_is_load(id_is_load), .i_id_is_mc(id_is_mc), .i_flush(flush),
        .o_fwd_sel(fwd_sel0), .o_stall(stall0), .o_mc_busy(busy0));

    fwd_hazard_ctrl #(.NSRC(NSRC), .NSTAGE(NSTAGE), .RAW(RAW), .MC_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rs_used(id_rs_used), .i_id_rd(id_rd), .i_id_reg_write(id_reg_write),
        .i_id_is_load(id_is_load), .i_id_is_mc(id_is_mc), .i_flush(flush),
        .o_fwd_sel(fwd_sel1), .o_stall(stall1), .o_mc_busy(busy1));

    typedef struct { bit v; int rd; bit rw; bit ld; bit mc; } mtag_t;
    typedef struct packed {
        logic [NSRC-1:0][SELW-1:0] sel0; logic stall0; logic busy0;
        logic [NSRC-1:0][SELW-1:0] sel1; logic stall1; logic busy1;
        int id;
    } exp_t;

    localparam mtag_t EMPTY = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0, mc: 1'b0};

    mtag_t st [2][1:NSTAGE];
    int    cnt [2];
    int    lat [2] = '{MC_LAT, 1};
    exp_t  q [$];

    bit c_v, c_rw, c_ld, c_mc, c_fl;
    int c_rs [NSRC];
    bit [NSRC-1:0] c_used;
    int c_rd;

    int checks = 0;
    int errors = 0;
    int stepn  = 0;
    bit last_stall = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp, input int id);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= NSTAGE; k++) st[m][k] = EMPTY;
            cnt[m] = 0;
        end
    endtask

    // Expected outputs for the current decode inputs, then (if adv) the
    // state after the next clock edge.
    task automatic model_cycle(input int m, input bit adv,
                               output logic [NSRC-1:0][SELW-1:0] sel,
                               output logic stl, output logic bsy);
        bit lu;
        int s;
        lu  = 1'b0;
        bsy = (cnt[m] > 0);
        for (int i = 0; i < NSRC; i++) begin
            s = 0;
            if (c_used[i] && c_rs[i] != 0)
                for (int k = 1; k <= NSTAGE; k++)
                    if (s == 0 && st[m][k].v && st[m][k].rw && st[m][k].rd == c_rs[i]) begin
                        if (k == 1 && st[m][k].ld) lu = 1'b1;
                        else s = k;
                    end
            sel[i] = SELW'(s);
        end
        stl = c_v && !c_fl && (lu || bsy);
        if (!adv) return;
        if (bsy) begin
            for (int k = NSTAGE; k >= 3; k--) st[m][k] = st[m][k-1];
            st[m][2] = EMPTY;
            cnt[m]   = cnt[m] - 1;
        end else begin
            for (int k = NSTAGE; k >= 2; k--) st[m][k] = st[m][k-1];
            if (c_v && !c_fl && !stl) begin
                st[m][1] = '{v: 1'b1, rd: c_rd, rw: c_rw, ld: c_ld, mc: c_mc};
                if (c_mc) cnt[m] = lat[m] - 1;
            end else begin
                st[m][1] = EMPTY;
            end
        end
    endtask

    // mode 0: normal cycle; 1: reset held through the edge; 2: reset pulse mid-cycle
    task automatic step(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                        input int rd, input bit rw, input bit ld, input bit mc,
                        input bit fl, input int mode);
        exp_t e;
        c_v = v; c_rs[0] = rs0; c_rs[1] = rs1; c_used = used;
        c_rd = rd; c_rw = rw; c_ld = ld; c_mc = mc; c_fl = fl;
        id_valid = v; id_rs[0] = RAW'(rs0); id_rs[1] = RAW'(rs1); id_rs_used = used;
        id_rd = RAW'(rd); id_reg_write = rw; id_is_load = ld; id_is_mc = mc; flush = fl;
        if (mode == 0) rst = 1'b0;
        if (mode == 1) begin rst = 1'b1; model_reset(); end
        if (mode == 2) begin #1; rst = 1'b1; model_reset(); end
        model_cycle(0, mode != 1, e.sel0, e.stall0, e.busy0);
        model_cycle(1, mode != 1, e.sel1, e.stall1, e.busy1);
        e.id = stepn;
        stepn++;
        last_stall = e.stall0;
        q.push_back(e);
        if (mode == 2) begin @(negedge clk); #2; rst = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fwd_sel",       32'(fwd_sel0), 32'(e.sel0),   e.id);
                chk("stall",         32'(stall0),   32'(e.stall0), e.id);
                chk("mc_busy",       32'(busy0),    32'(e.busy0),  e.id);
                chk("lat1_fwd_sel",  32'(fwd_sel1), 32'(e.sel1),   e.id);
                chk("lat1_stall",    32'(stall1),   32'(e.stall1), e.id);
                chk("lat1_mc_busy",  32'(busy1),    32'(e.busy1),  e.id);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit r_v, r_rw, r_ld, r_mc, r_fl;
        int r_rs0, r_rs1, r_rd, mode;
        bit [1:0] r_used;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        // reset held with an instruction present
        step(1'b1, 5, 7, 2'b11, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step(1'b1, 5, 7, 2'b11, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        // ALU forward from EX then MEM
        step(1'b1, 1, 2, 2'b11, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 5, 0, 2'b01, 6, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 5, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // load-use on rs2, one stall then forward from MEM
        step(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 0, 7, 2'b10, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 0, 7, 2'b10, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // youngest writer wins; x0 never forwards; unused source stays 0
        step(1'b1, 0, 0, 2'b00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 0, 0, 2'b00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 0, 0, 2'b00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 3, 3, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 0, 0, 2'b11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // multicycle op, decode held until it completes
        step(1'b1, 0, 0, 2'b00, 9, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int j = 0; j < 4; j++) step(1'b1, 9, 0, 2'b01, 10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // flush overrides a load-use stall
        step(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 0, 7, 2'b10, 8, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 0, 7, 2'b10, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // reset in the middle of a multicycle op
        step(1'b1, 0, 0, 2'b00, 9, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 9, 0, 2'b01, 10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 9, 0, 2'b01, 10, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        step(1'b1, 10, 0, 2'b01, 11, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(3);
        // randomized traffic on a small register set to force overlaps
        r_v = 0; r_rs0 = 0; r_rs1 = 0; r_used = 0; r_rd = 0; r_rw = 0; r_ld = 0; r_mc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(last_stall && ($urandom_range(3) != 0))) begin
                r_v    = ($urandom_range(3) != 0);
                r_rs0  = $urandom_range(3);
                r_rs1  = $urandom_range(3);
                r_used = 2'($urandom_range(3));
                r_rd   = $urandom_range(3);
                r_rw   = ($urandom_range(4) != 0);
                r_ld   = ($urandom_range(3) == 0);
                r_mc   = ($urandom_range(9) == 0);
            end
            r_fl = ($urandom_range(9) == 0);
            mode = ($urandom_range(199) == 0) ? 2 : 0;
            step(r_v, r_rs0, r_rs1, r_used, r_rd, r_rw, r_ld, r_mc, r_fl, mode);
        end
        repeat (2) @(posedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
